// File: rtl/wait_state_controller_if.sv
// rtl/wait_state_controller_if.sv - 68k DTACK/BERR bus bundle between CPU side and wait-state controller
// The master side is the CPU/decoder; the slave side is the controller.

interface wait_state_controller_if;
    logic       AS_L;
    logic [3:0] RegionSelect_H;
    logic [3:0] ExtDtack_L;
    logic       ClearStatus_H;
    logic       DtackOut_L;
    logic       BErrOut_L;
    logic       BusTimeout_H;
    logic [2:0] TimeoutRegion;

    modport master (
        output AS_L,
        output RegionSelect_H,
        output ExtDtack_L,
        output ClearStatus_H,
        input  DtackOut_L,
        input  BErrOut_L,
        input  BusTimeout_H,
        input  TimeoutRegion
    );

    modport slave (
        input  AS_L,
        input  RegionSelect_H,
        input  ExtDtack_L,
        input  ClearStatus_H,
        output DtackOut_L,
        output BErrOut_L,
        output BusTimeout_H,
        output TimeoutRegion
    );
endinterface

// File: rtl/wait_state_controller.sv
// rtl/wait_state_controller.sv - per-region wait-state DTACK/BERR sequencer with bus-timeout watchdog
// Region is latched at the strobe edge; DTACK/BERR are registered and released on AS_L negation.

module wait_state_controller #(
    parameter int         WS0            = 0,
    parameter int         WS1            = 0,
    parameter int         WS2            = 2,
    parameter int         WS3            = 4,
    parameter logic [3:0] EXT_MASK       = 4'b0011,
    parameter int         TIMEOUT_CYCLES = 1023,
    parameter int         CNT_W          = 10
) (
    input  logic                 Clk,
    input  logic                 Reset_L,
    wait_state_controller_if.slave bus
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] COUNT   = 3'd1;
    localparam logic [2:0] EXTWAIT = 3'd2;
    localparam logic [2:0] ACK     = 3'd3;
    localparam logic [2:0] BERR    = 3'd4;

    localparam logic [2:0]       REGION_INTERNAL = 3'd4;
    localparam logic [CNT_W-1:0] TO_LAST         = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_ONE        = CNT_W'(1);

    logic [2:0]       state;
    logic [2:0]       region;
    logic [2:0]       selRegion;
    logic [2:0]       timeoutRegion;
    logic [CNT_W-1:0] waitCnt;
    logic [CNT_W-1:0] toCnt;
    logic [CNT_W-1:0] selWs;
    logic             selExt;
    logic             dtackReg;
    logic             berrReg;
    logic             busTimeout;
    logic             extDtackSel;
    logic             extAck;
    logic             timeoutHit;

    // Lowest-index select wins when the decoder asserts more than one region.
    always_comb begin
        selRegion = REGION_INTERNAL;
        if (bus.RegionSelect_H[0]) begin
            selRegion = 3'd0;
        end else if (bus.RegionSelect_H[1]) begin
            selRegion = 3'd1;
        end else if (bus.RegionSelect_H[2]) begin
            selRegion = 3'd2;
        end else if (bus.RegionSelect_H[3]) begin
            selRegion = 3'd3;
        end
    end

    always_comb begin
        selWs  = '0;
        selExt = 1'b0;
        case (selRegion)
            3'd0: begin
                selWs  = CNT_W'(WS0);
                selExt = EXT_MASK[0];
            end
            3'd1: begin
                selWs  = CNT_W'(WS1);
                selExt = EXT_MASK[1];
            end
            3'd2: begin
                selWs  = CNT_W'(WS2);
                selExt = EXT_MASK[2];
            end
            3'd3: begin
                selWs  = CNT_W'(WS3);
                selExt = EXT_MASK[3];
            end
            default: begin
                selWs  = '0;
                selExt = 1'b0;
            end
        endcase
    end

    // A device acknowledge on the timeout edge takes priority over BERR.
    always_comb begin
        extDtackSel = bus.ExtDtack_L[region[1:0]];
        extAck      = (state == EXTWAIT) && !bus.AS_L && !extDtackSel;
        timeoutHit  = (state == EXTWAIT) && !bus.AS_L && extDtackSel && (toCnt == TO_LAST);
    end

    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            state    <= IDLE;
            region   <= REGION_INTERNAL;
            waitCnt  <= '0;
            toCnt    <= '0;
            dtackReg <= 1'b1;
            berrReg  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.AS_L) begin
                        region <= selRegion;
                        toCnt  <= '0;
                        if (selExt) begin
                            state <= EXTWAIT;
                        end else if (selWs == '0) begin
                            state    <= ACK;
                            dtackReg <= 1'b0;
                        end else begin
                            state   <= COUNT;
                            waitCnt <= selWs;
                        end
                    end
                end
                COUNT: begin
                    waitCnt <= waitCnt - WAIT_ONE;
                    if (bus.AS_L) begin
                        state <= IDLE;
                    end else if (waitCnt == WAIT_ONE) begin
                        state    <= ACK;
                        dtackReg <= 1'b0;
                    end
                end
                EXTWAIT: begin
                    if (bus.AS_L) begin
                        state <= IDLE;
                    end else if (extAck) begin
                        state    <= ACK;
                        dtackReg <= 1'b0;
                    end else if (timeoutHit) begin
                        state   <= BERR;
                        berrReg <= 1'b0;
                    end else begin
                        toCnt <= toCnt + WAIT_ONE;
                    end
                end
                ACK: begin
                    if (bus.AS_L) begin
                        state    <= IDLE;
                        dtackReg <= 1'b1;
                    end
                end
                BERR: begin
                    if (bus.AS_L) begin
                        state   <= IDLE;
                        berrReg <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    dtackReg <= 1'b1;
                    berrReg  <= 1'b1;
                end
            endcase
        end
    end

    // Sticky status: a timeout on the same edge as a clear leaves the flag set.
    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            busTimeout    <= 1'b0;
            timeoutRegion <= REGION_INTERNAL;
        end else if (timeoutHit) begin
            busTimeout    <= 1'b1;
            timeoutRegion <= region;
        end else if (bus.ClearStatus_H) begin
            busTimeout <= 1'b0;
        end
    end

    assign bus.DtackOut_L    = dtackReg;
    assign bus.BErrOut_L     = berrReg;
    assign bus.BusTimeout_H  = busTimeout;
    assign bus.TimeoutRegion = timeoutRegion;

endmodule

// File: tb/tb_wait_state_controller.sv
// tb/tb_wait_state_controller.sv - directed plus randomized bench for wait_state_controller
// Expected responses come from a per-transaction latency model of the region rules.

module tb_wait_state_controller;

    localparam int         T    = 1023;
    localparam logic [3:0] EXTM = 4'b0011;

    int wsTab [4] = '{0, 0, 2, 4};

    logic Clk     = 1'b0;
    logic Reset_L = 1'b0;

    wait_state_controller_if bus ();

    wait_state_controller #(
        .WS0(0), .WS1(0), .WS2(2), .WS3(4),
        .EXT_MASK(EXTM), .TIMEOUT_CYCLES(T), .CNT_W(10)
    ) dut (
        .Clk(Clk),
        .Reset_L(Reset_L),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    int tests     = 0;
    int fails     = 0;
    int expFlag   = 0;
    int expRegion = 4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic int regionOf(input logic [3:0] sel);
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) return i;
        end
        return 4;
    endfunction

    // kind: 0 = no response (aborted), 1 = DTACK, 2 = BERR; at = edge offset from the strobe edge
    function automatic void model(input logic [3:0] sel, input int extAt, input int abortAt,
                                  output int kind, output int at);
        int r;
        r = regionOf(sel);
        if (r == 4) begin
            kind = 1;
            at   = 0;
        end else if (EXTM[r]) begin
            if (extAt >= 1 && extAt <= T) begin
                kind = 1;
                at   = extAt;
            end else begin
                kind = 2;
                at   = T;
            end
        end else begin
            kind = 1;
            at   = wsTab[r];
        end
        if (abortAt >= 1 && abortAt <= at) begin
            kind = 0;
            at   = -1;
        end
    endfunction

    task automatic runCycle(input string name, input logic [3:0] sel, input int extAt,
                            input int abortAt, input int clrAt, input int holdExtra,
                            input bit toggle);
        int r, kind, at, ek, eat, bothLow, holdBad, lim, endEdge;
        logic [3:0] ext;
        kind    = 0;
        at      = -1;
        bothLow = 0;
        holdBad = 0;
        r       = regionOf(sel);
        model(sel, extAt, abortAt, ek, eat);
        ext = 4'($urandom);
        if (r < 4) ext[r] = 1'b1;
        bus.ExtDtack_L     = ext;
        bus.RegionSelect_H = sel;
        bus.AS_L           = 1'b0;
        lim = (abortAt > 0) ? abortAt + 2 : T + 4;
        for (int k = 0; k <= lim; k++) begin
            tick();
            if (bus.DtackOut_L === 1'b0 && bus.BErrOut_L === 1'b0) bothLow++;
            if (bus.DtackOut_L === 1'b0) begin
                kind = 1;
                at   = k;
            end else if (bus.BErrOut_L === 1'b0) begin
                kind = 2;
                at   = k;
            end
            if (kind != 0 || k == lim) break;
            bus.ClearStatus_H = (clrAt == k + 1);
            if (toggle) bus.RegionSelect_H = 4'($urandom);
            if (r < 4 && extAt == k + 1) bus.ExtDtack_L[r] = 1'b0;
            if (abortAt == k + 1) bus.AS_L = 1'b1;
        end
        bus.ClearStatus_H = 1'b0;
        for (int h = 0; h < holdExtra; h++) begin
            tick();
            if (kind == 1 && bus.DtackOut_L !== 1'b0) holdBad++;
            if (kind == 2 && bus.BErrOut_L !== 1'b0) holdBad++;
            if (bus.DtackOut_L === 1'b0 && bus.BErrOut_L === 1'b0) bothLow++;
        end
        bus.AS_L = 1'b1;
        tick();
        chk({name, " kind"}, kind, ek);
        chk({name, " edge"}, at, eat);
        chk({name, " release"}, {bus.DtackOut_L, bus.BErrOut_L}, 2'b11);
        chk({name, " bothLow"}, bothLow, 0);
        chk({name, " hold"}, holdBad, 0);
        endEdge = (ek == 0) ? abortAt + 2 : eat;
        if (clrAt >= 1 && clrAt <= endEdge) expFlag = 0;
        if (ek == 2) begin
            expFlag   = 1;
            expRegion = r;
        end
        chk({name, " flag"}, bus.BusTimeout_H, expFlag);
        chk({name, " region"}, bus.TimeoutRegion, expRegion);
        bus.ExtDtack_L     = '1;
        bus.RegionSelect_H = '0;
    endtask

    initial begin
        logic [3:0] sel;
        int pick, extAt, abortAt, clrAt;

        bus.AS_L           = 1'b1;
        bus.RegionSelect_H = '0;
        bus.ExtDtack_L     = '1;
        bus.ClearStatus_H  = 1'b0;
        Reset_L            = 1'b0;
        repeat (3) tick();
        chk("reset dtack", bus.DtackOut_L, 1);
        chk("reset berr", bus.BErrOut_L, 1);
        chk("reset flag", bus.BusTimeout_H, 0);
        chk("reset region", bus.TimeoutRegion, 4);
        Reset_L = 1'b1;
        tick();

        runCycle("internal", 4'b0000, 0, 0, 0, 3, 1'b0);
        runCycle("r3 ws4 toggle", 4'b1000, 0, 0, 0, 1, 1'b1);
        runCycle("r0 ext7", 4'b0001, 7, 0, 0, 0, 1'b0);
        runCycle("r0 ext on timeout edge", 4'b0001, T, 0, 0, 0, 1'b0);
        runCycle("r1 timeout", 4'b0010, 0, 0, 0, 2, 1'b0);

        bus.ClearStatus_H = 1'b1;
        tick();
        bus.ClearStatus_H = 1'b0;
        expFlag = 0;
        chk("clear flag", bus.BusTimeout_H, 0);
        chk("clear keeps region", bus.TimeoutRegion, 1);

        runCycle("r2 abort", 4'b0100, 0, 1, 0, 0, 1'b0);
        runCycle("internal after abort", 4'b0000, 0, 0, 0, 0, 1'b0);
        runCycle("timeout with same-edge clear", 4'b0010, 0, 0, T, 0, 1'b0);

        bus.RegionSelect_H = '0;
        bus.AS_L = 1'b0;
        tick();
        chk("pre-reset ack", bus.DtackOut_L, 0);
        #2 Reset_L = 1'b0;
        #1;
        chk("async reset dtack", bus.DtackOut_L, 1);
        chk("async reset berr", bus.BErrOut_L, 1);
        chk("async reset flag", bus.BusTimeout_H, 0);
        chk("async reset region", bus.TimeoutRegion, 4);
        expFlag   = 0;
        expRegion = 4;
        bus.AS_L  = 1'b1;
        tick();
        Reset_L = 1'b1;
        tick();
        chk("idle after reset", bus.DtackOut_L, 1);
        runCycle("internal after reset", 4'b0000, 0, 0, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            pick = $urandom_range(0, 5);
            if (pick == 0) sel = 4'b0000;
            else if (pick < 5) sel = 4'(1 << (pick - 1));
            else sel = 4'($urandom);
            extAt   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 30);
            abortAt = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 6) : 0;
            clrAt   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
            runCycle("random", sel, extAt, abortAt, clrAt, $urandom_range(0, 3),
                     1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wait_state_controller.md
# wait_state_controller

Clocked DTACK/BERR sequencer for the 68k bus. It replaces the purely combinational DTACK path with a per-region wait-state engine. Each cycle is acknowledged either immediately, after a fixed wait-state count, or when a slow device (DRAM, CAN, Flash) returns its own DTACK. A bus-timeout watchdog raises BERR if no acknowledge arrives. It sits between the address decoder and the CPU's DTACK_L/BERR_L pins.

## Interface
- WS0, default 0: wait states for region 0 (counter mode).
- WS1, default 0: wait states for region 1.
- WS2, default 2: wait states for region 2.
- WS3, default 4: wait states for region 3.
- EXT_MASK, default 4'b0011: bit r=1 means region r is acknowledged by ExtDtack_L[r], not by its counter.
- TIMEOUT_CYCLES, default 1023: Clk cycles without acknowledge before BERR. Must be greater than every WSr and at most 2^CNT_W−1.
- CNT_W, default 10: width of the wait and timeout counters.
- Clk  in  1  system clock. CPU bus signals are synchronous to it.
- Reset_L  in  1  asynchronous, active-low reset.
- AS_L  in  1  CPU address strobe.
- RegionSelect_H  in  4  address-decoder region selects. All zero means an internal fast device.
- ExtDtack_L  in  4  per-region device acknowledges; used only where EXT_MASK=1.
- ClearStatus_H  in  1  clears the sticky timeout status.
- DtackOut_L  out  1  registered DTACK to the CPU.
- BErrOut_L  out  1  registered BERR to the CPU.
- BusTimeout_H  out  1  sticky flag: a timeout has occurred.
- TimeoutRegion  out  3  region index of the last timeout; 3'd4 means none-selected/internal.

## Operation
- States: IDLE, COUNT, EXTWAIT, ACK, BERR.
- Reset (asynchronous, Reset_L=0):
  - state=IDLE.
  - DtackOut_L=1, BErrOut_L=1.
  - BusTimeout_H=0, TimeoutRegion=3'd4.
  - Counters = 0.
- IDLE, when AS_L is sampled 0:
  - Latch the region r as the lowest-index set bit of RegionSelect_H, or "internal" if no bit is set.
  - The region stays latched for the whole cycle; later changes to RegionSelect_H are ignored.
  - Internal region, or counter-mode region with WSr=0: go to ACK.
  - Counter-mode region with WSr>0: go to COUNT, load wait counter=WSr.
  - External region: go to EXTWAIT.
  - Timeout counter cleared to 0.
- COUNT:
  - Wait counter decrements each cycle.
  - When it is 1, go to ACK.
- EXTWAIT:
  - Go to ACK on the cycle ExtDtack_L[r] is sampled 0.
  - Timeout counter increments each cycle.
  - When the count reaches TIMEOUT_CYCLES−1 with no ExtDtack, go to BERR.
  - If ExtDtack_L and the timeout occur on the same cycle, ACK wins.
- ACK: DtackOut_L=0. Hold until AS_L is sampled 1, then go to IDLE with DtackOut_L=1.
- BERR:
  - BErrOut_L=0.
  - BusTimeout_H is set and TimeoutRegion=r, both on the entry edge.
  - Hold until AS_L is sampled 1, then go to IDLE with BErrOut_L=1.
- Aborted cycle: AS_L sampled 1 in COUNT or EXTWAIT returns to IDLE. No DTACK, no BERR.
- DtackOut_L and BErrOut_L are never low at the same time.
- BusTimeout_H:
  - Cleared by ClearStatus_H=1.
  - If a set and a clear happen on the same edge, the set wins.
  - TimeoutRegion keeps its value when the flag is cleared.

## Timing
- AS_L low is first sampled at rising edge n.
- DtackOut_L low from edge n for internal regions and for counter regions with WS=0. This is one register stage after the strobe and matches the zero-wait combinational behaviour.
- Counter region with WSr>0: DtackOut_L low from edge n+WSr.
- External region: ExtDtack_L low sampled at edge m → DtackOut_L low from edge m. Minimum latency is edge n+1.
- Timeout: BErrOut_L low from edge n+TIMEOUT_CYCLES.
- Release: AS_L high sampled at edge k → DtackOut_L/BErrOut_L high from edge k.
- Back-to-back cycles: a new AS_L low sampled on the edge after release starts a fresh cycle. No dead cycle is required beyond the CPU's own AS_L negation.
- Reset asserted mid-cycle: outputs go high immediately and asynchronously. After Reset_L is released, the state machine waits in IDLE for the next AS_L falling sample.

## Test plan
- Internal access: RegionSelect_H=0, AS_L low at edge 10 → DtackOut_L low at edge 10, high at the edge AS_L is sampled high.
- Region 3 (WS3=4): AS_L low at edge 20 → DtackOut_L low at edge 24. Toggling RegionSelect_H during the wait has no effect.
- Region 0 external: ExtDtack_L[0] low at edge n+7 → DtackOut_L low at n+7. Also drive ExtDtack_L[0] low on the timeout edge → DTACK, no BERR.
- Timeout: region 1 external, ExtDtack_L held high → BErrOut_L low at n+1023, BusTimeout_H=1, TimeoutRegion=1. ClearStatus_H pulse → flag 0, TimeoutRegion still 1.
- Abort: region 2 (WS2=2), AS_L raised after 1 cycle → no DTACK. The next internal cycle acks normally.
- Reset_L pulsed low while in ACK → DtackOut_L=1 immediately, state IDLE, BusTimeout_H=0.
